// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus transmit beat generator: FSM states and the
// per-lane DDR byte pair that is handed to the output cells each clock.
package hyperbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    DATA_LO,
    DATA_HI
  } state_t;

  localparam int CA_BEATS = 3;
  localparam logic [1:0] CA_LAST = 2'(CA_BEATS - 1);

  // d0 is driven in the clock-high half, d1 in the clock-low half
  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rwds0;
    logic       rwds1;
  } beat_t;

  function automatic beat_t make_beat(input logic [7:0] d0, input logic [7:0] d1,
                                      input logic rwds0, input logic rwds1);
    beat_t b;
    b.d0    = d0;
    b.d1    = d1;
    b.rwds0 = rwds0;
    b.rwds1 = rwds1;
    return b;
  endfunction

endpackage

// File: rtl/hyperbus_tx_beat.sv
// Turns a HyperBus transaction (CA, latency, write words) into one registered
// DDR beat per clock for the PHY output cells; reads stop after the CA phase.
module hyperbus_tx_beat
  import hyperbus_pkg::*;
#(
  parameter int LAT_W = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trans_valid_i,
  output logic             trans_ready_o,
  input  logic [47:0]      trans_ca_i,
  input  logic             trans_write_i,
  input  logic [LAT_W-1:0] trans_lat_i,
  input  logic [LEN_W-1:0] trans_len_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  output logic [7:0]       dq_d0_o,
  output logic [7:0]       dq_d1_o,
  output logic             rwds_d0_o,
  output logic             rwds_d1_o,
  output logic             dq_oe_o,
  output logic             rwds_oe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o
);

  state_t           state;
  beat_t            beat_q;
  logic [31:0]      ca_lo;
  logic [1:0]       ca_idx;
  logic             is_write;
  logic [LAT_W-1:0] lat_cnt;
  logic [LEN_W-1:0] len_cnt;
  logic [15:0]      hold_data;
  logic [1:0]       hold_mask;
  logic             trans_ready_q;
  logic             wdata_ready_q;
  logic             dq_oe_q;
  logic             rwds_oe_q;
  logic             busy_q;
  logic             done_q;
  logic             underrun_q;

  // Handshake flags are registered from the next state so they line up with
  // the state the FSM actually sits in during the following cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      beat_q        <= '0;
      ca_lo         <= '0;
      ca_idx        <= '0;
      is_write      <= 1'b0;
      lat_cnt       <= '0;
      len_cnt       <= '0;
      hold_data     <= '0;
      hold_mask     <= '0;
      trans_ready_q <= 1'b0;
      wdata_ready_q <= 1'b0;
      dq_oe_q       <= 1'b0;
      rwds_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (trans_ready_q && trans_valid_i) begin
            beat_q        <= make_beat(trans_ca_i[47:40], trans_ca_i[39:32], 1'b0, 1'b0);
            dq_oe_q       <= 1'b1;
            rwds_oe_q     <= 1'b0;
            ca_lo         <= trans_ca_i[31:0];
            ca_idx        <= 2'd1;
            is_write      <= trans_write_i;
            lat_cnt       <= trans_lat_i;
            len_cnt       <= trans_len_i;
            underrun_q    <= 1'b0;
            trans_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= CA;
          end else begin
            beat_q        <= '0;
            dq_oe_q       <= 1'b0;
            rwds_oe_q     <= 1'b0;
            trans_ready_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end

        CA: begin
          if (ca_idx == CA_LAST) begin
            beat_q <= make_beat(ca_lo[15:8], ca_lo[7:0], 1'b0, 1'b0);
            if (!is_write || (len_cnt == '0 && lat_cnt == '0)) begin
              done_q        <= 1'b1;
              trans_ready_q <= 1'b1;
              busy_q        <= 1'b0;
              state         <= IDLE;
            end else if (lat_cnt != '0) begin
              state <= LAT;
            end else begin
              wdata_ready_q <= 1'b1;
              state         <= DATA_LO;
            end
          end else begin
            beat_q <= make_beat(ca_lo[31:24], ca_lo[23:16], 1'b0, 1'b0);
            ca_idx <= ca_idx + 2'd1;
          end
        end

        LAT: begin
          beat_q    <= '0;
          dq_oe_q   <= 1'b0;
          rwds_oe_q <= 1'b0;
          lat_cnt   <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            if (len_cnt == '0) begin
              done_q        <= 1'b1;
              trans_ready_q <= 1'b1;
              busy_q        <= 1'b0;
              state         <= IDLE;
            end else begin
              wdata_ready_q <= 1'b1;
              state         <= DATA_LO;
            end
          end
        end

        // The bus cannot stall, so a missing word becomes a fully masked pair
        DATA_LO: begin
          dq_oe_q       <= 1'b1;
          rwds_oe_q     <= 1'b1;
          wdata_ready_q <= 1'b0;
          state         <= DATA_HI;
          if (wdata_valid_i) begin
            beat_q    <= make_beat(wdata_i[15:8], wdata_i[7:0], ~wstrb_i[1], ~wstrb_i[0]);
            hold_data <= wdata_i[31:16];
            hold_mask <= ~wstrb_i[3:2];
          end else begin
            beat_q     <= make_beat(8'h00, 8'h00, 1'b1, 1'b1);
            hold_data  <= '0;
            hold_mask  <= 2'b11;
            underrun_q <= 1'b1;
          end
        end

        DATA_HI: begin
          beat_q  <= make_beat(hold_data[15:8], hold_data[7:0], hold_mask[1], hold_mask[0]);
          len_cnt <= len_cnt - LEN_W'(1);
          if (len_cnt == LEN_W'(1)) begin
            done_q        <= 1'b1;
            trans_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            state         <= IDLE;
          end else begin
            wdata_ready_q <= 1'b1;
            state         <= DATA_LO;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign trans_ready_o = trans_ready_q;
  assign wdata_ready_o = wdata_ready_q;
  assign dq_d0_o       = beat_q.d0;
  assign dq_d1_o       = beat_q.d1;
  assign rwds_d0_o     = beat_q.rwds0;
  assign rwds_d1_o     = beat_q.rwds1;
  assign dq_oe_o       = dq_oe_q;
  assign rwds_oe_o     = rwds_oe_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign underrun_o    = underrun_q;

endmodule
